// File: rtl/rca_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder controller around a 4-bit ripple-carry adder.
// Operands are fed LSB nibble first; carries chain through c_reg.
module rca_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] result_nx;
  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic             last_nib;

  assign last_nib = (cnt == CW'(NIB - 1));

  // New sum nibbles enter at the top so the first one ends up in bits [3:0].
  generate
    if (WIDTH == 4) begin : g_single
      assign result_nx = add_sum;
    end else begin : g_multi
      assign result_nx = {add_sum, result[WIDTH-1:4]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_nib) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      c_reg     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= op_a;
            b_sh  <= op_b;
            c_reg <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          result <= result_nx;
          c_reg  <= add_cout;
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          cnt    <= cnt + CW'(1);
          if (last_nib) carry_out <= add_cout;
        end
        default: ;
      endcase
    end
  end

  // Adder inputs are forced to zero outside RUN so the adder sits quiet.
  assign ready   = (state == IDLE);
  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign add_a   = busy ? a_sh[3:0] : 4'h0;
  assign add_b   = busy ? b_sh[3:0] : 4'h0;
  assign add_cin = busy & c_reg;

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Self-checking bench for rca_nibble_sequencer at WIDTH=16 (directed) and
// WIDTH=8/32 (randomized against a plain-arithmetic reference sum).
module tb_rca_nibble_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // WIDTH=16 instance with a 4-bit ripple adder behaviour on its adder ports
  logic        s16, ci16, rdy16, bsy16, dn16, co16, ac16, cout16;
  logic [15:0] a16, b16, res16;
  logic [3:0]  aa16, ab16, sum16;
  assign {cout16, sum16} = 5'(aa16) + 5'(ab16) + 5'(ac16);

  rca_nibble_sequencer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .op_a(a16), .op_b(b16), .cin(ci16),
    .ready(rdy16), .busy(bsy16), .done(dn16), .result(res16), .carry_out(co16),
    .add_a(aa16), .add_b(ab16), .add_cin(ac16), .add_sum(sum16), .add_cout(cout16)
  );

  logic        s8, ci8, rdy8, bsy8, dn8, co8, ac8, cout8;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  aa8, ab8, sum8;
  assign {cout8, sum8} = 5'(aa8) + 5'(ab8) + 5'(ac8);

  rca_nibble_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .op_a(a8), .op_b(b8), .cin(ci8),
    .ready(rdy8), .busy(bsy8), .done(dn8), .result(res8), .carry_out(co8),
    .add_a(aa8), .add_b(ab8), .add_cin(ac8), .add_sum(sum8), .add_cout(cout8)
  );

  logic        s32, ci32, rdy32, bsy32, dn32, co32, ac32, cout32;
  logic [31:0] a32, b32, res32;
  logic [3:0]  aa32, ab32, sum32;
  assign {cout32, sum32} = 5'(aa32) + 5'(ab32) + 5'(ac32);

  rca_nibble_sequencer #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(s32), .op_a(a32), .op_b(b32), .cin(ci32),
    .ready(rdy32), .busy(bsy32), .done(dn32), .result(res32), .carry_out(co32),
    .add_a(aa32), .add_b(ab32), .add_cin(ac32), .add_sum(sum32), .add_cout(cout32)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one WIDTH=16 operation and follows it until done (bounded).
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c,
                       output logic [16:0] sum, output int edges, output int busyc,
                       output logic [3:0] cins, output logic ok);
    a16 = a; b16 = b; ci16 = c; s16 = 1'b1;
    step();
    s16 = 1'b0;
    edges = 0; busyc = 0; cins = 4'h0; ok = 1'b0;
    while (!ok && edges <= 12) begin
      if (dn16) ok = 1'b1;
      else begin
        if (bsy16) begin
          if (busyc < 4) cins[busyc] = ac16;
          busyc++;
        end
        step();
        edges++;
      end
    end
    sum = {co16, res16};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s16 = 0; s8 = 0; s32 = 0;
    a16 = '0; b16 = '0; ci16 = 0; a8 = '0; b8 = '0; ci8 = 0; a32 = '0; b32 = '0; ci32 = 0;
    #2;
    checks++;
    if ({rdy16, bsy16, dn16} !== 3'b100) begin
      errors++; $display("[TB] FAIL reset_flags actual=%b required=100", {rdy16, bsy16, dn16});
    end
    checks++;
    if ({co16, res16} !== 17'h0) begin
      errors++; $display("[TB] FAIL reset_result actual=%h required=0", {co16, res16});
    end
    checks++;
    if ({aa16, ab16, ac16} !== 9'h0) begin
      errors++; $display("[TB] FAIL reset_adder_in actual=%h required=0", {aa16, ab16, ac16});
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [16:0] sum; int edges, busyc; logic [3:0] cins; logic ok;
    run16(16'h1234, 16'h4321, 1'b0, sum, edges, busyc, cins, ok);
    checks++;
    if (!ok || edges != 4) begin
      errors++; $display("[TB] FAIL basic_latency actual=%0d ok=%b required=4", edges, ok);
    end
    checks++;
    if (busyc != 4) begin
      errors++; $display("[TB] FAIL basic_busy_cycles actual=%0d required=4", busyc);
    end
    checks++;
    if (sum !== 17'h05555) begin
      errors++; $display("[TB] FAIL basic_sum actual=%h required=05555", sum);
    end
    step();
    checks++;
    if (dn16 !== 1'b0 || rdy16 !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_done_width actual done=%b ready=%b required done=0 ready=1", dn16, rdy16);
    end
  endtask

  task automatic test_carry_chain();
    logic [16:0] sum; int edges, busyc; logic [3:0] cins; logic ok;
    run16(16'hFFFF, 16'h0001, 1'b0, sum, edges, busyc, cins, ok);
    checks++;
    if (!ok || sum !== 17'h10000) begin
      errors++; $display("[TB] FAIL carry_ripple actual=%h ok=%b required=10000", sum, ok);
    end
    checks++;
    if (cins !== 4'b1110) begin
      errors++; $display("[TB] FAIL carry_cin_trace actual=%b required=1110", cins);
    end
    step();
    run16(16'hFFFF, 16'hFFFF, 1'b1, sum, edges, busyc, cins, ok);
    checks++;
    if (!ok || sum !== 17'h1FFFF) begin
      errors++; $display("[TB] FAIL carry_all_ones actual=%h ok=%b required=1ffff", sum, ok);
    end
    step();
    run16(16'h8000, 16'h8000, 1'b0, sum, edges, busyc, cins, ok);
    checks++;
    if (!ok || sum !== 17'h10000) begin
      errors++; $display("[TB] FAIL carry_msb actual=%h ok=%b required=10000", sum, ok);
    end
    step();
  endtask

  task automatic test_ignore_start();
    int n = 0; logic ok = 1'b0;
    a16 = 16'h00FF; b16 = 16'h0001; ci16 = 1'b0; s16 = 1'b1;
    step();
    a16 = 16'hAAAA; b16 = 16'h5555; ci16 = 1'b1;
    while (!ok && n < 12) begin
      checks++;
      if (rdy16 !== 1'b0) begin
        errors++; $display("[TB] FAIL ignore_ready cycle=%0d actual=%b required=0", n, rdy16);
      end
      if (dn16) ok = 1'b1;
      else begin step(); n++; end
    end
    s16 = 1'b0;
    checks++;
    if (!ok || {co16, res16} !== 17'h00100) begin
      errors++; $display("[TB] FAIL ignore_sum actual=%h ok=%b required=00100", {co16, res16}, ok);
    end
    step();
    checks++;
    if (rdy16 !== 1'b1 || bsy16 !== 1'b0 || res16 !== 16'h0100) begin
      errors++; $display("[TB] FAIL ignore_second_req actual ready=%b busy=%b res=%h required 1 0 0100", rdy16, bsy16, res16);
    end
  endtask

  task automatic test_back_to_back();
    int t = 0, last = -1, pulses = 0;
    a16 = 16'h0001; b16 = 16'h0001; ci16 = 1'b0; s16 = 1'b1;
    while (pulses < 3 && t < 60) begin
      step(); t++;
      if (dn16) begin
        checks++;
        if (res16 !== 16'h0002) begin
          errors++; $display("[TB] FAIL b2b_sum actual=%h required=0002", res16);
        end
        if (last >= 0) begin
          checks++;
          if (t - last != 6) begin
            errors++; $display("[TB] FAIL b2b_interval actual=%0d required=6", t - last);
          end
        end
        last = t; pulses++;
        step(); t++;
        step(); t++;
        checks++;
        if (res16 !== 16'h0002 || bsy16 !== 1'b1) begin
          errors++; $display("[TB] FAIL b2b_hold actual res=%h busy=%b required 0002 1", res16, bsy16);
        end
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++; $display("[TB] FAIL b2b_pulses actual=%0d required=3", pulses);
    end
    s16 = 1'b0;
    for (int i = 0; i < 10 && !rdy16; i++) step();
  endtask

  task automatic test_reset_midrun();
    logic [16:0] sum; int edges, busyc; logic [3:0] cins; logic ok;
    a16 = 16'h1111; b16 = 16'h2222; ci16 = 1'b0; s16 = 1'b1;
    step();
    s16 = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({co16, res16} !== 17'h0 || {rdy16, bsy16, dn16} !== 3'b100) begin
      errors++; $display("[TB] FAIL midrun_reset actual sum=%h flags=%b required 0 100", {co16, res16}, {rdy16, bsy16, dn16});
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (dn16 !== 1'b0 || rdy16 !== 1'b1) begin
        errors++; $display("[TB] FAIL midrun_no_done cycle=%0d actual done=%b ready=%b required 0 1", i, dn16, rdy16);
      end
    end
    run16(16'h1111, 16'h2222, 1'b0, sum, edges, busyc, cins, ok);
    checks++;
    if (!ok || sum !== 17'h03333) begin
      errors++; $display("[TB] FAIL midrun_rerun actual=%h ok=%b required=03333", sum, ok);
    end
    step();
  endtask

  task automatic test_random_w8();
    logic [7:0] a, b; logic c; logic [8:0] exp; logic ok; int n;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      exp = 9'(a) + 9'(b) + 9'(c);
      a8 = a; b8 = b; ci8 = c; s8 = 1'b1;
      step();
      s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      ok = 1'b0; n = 0;
      while (!ok && n < 10) begin
        if (dn8) ok = 1'b1; else begin step(); n++; end
      end
      checks++;
      if (!ok || {co8, res8} !== exp) begin
        errors++; $display("[TB] FAIL rand8 a=%h b=%h c=%b actual=%h ok=%b required=%h", a, b, c, {co8, res8}, ok, exp);
      end
      step();
    end
  endtask

  task automatic test_random_w32();
    logic [31:0] a, b; logic c; logic [32:0] exp; logic ok; int n;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom; c = 1'($urandom);
      if (i % 50 == 0) begin a = 32'hFFFF_FFFF; b = 32'(i / 50); end
      exp = 33'(a) + 33'(b) + 33'(c);
      a32 = a; b32 = b; ci32 = c; s32 = 1'b1;
      step();
      s32 = 1'b0; a32 = $urandom; b32 = $urandom;
      ok = 1'b0; n = 0;
      while (!ok && n < 16) begin
        if (dn32) ok = 1'b1; else begin step(); n++; end
      end
      checks++;
      if (!ok || {co32, res32} !== exp) begin
        errors++; $display("[TB] FAIL rand32 a=%h b=%h c=%b actual=%h ok=%b required=%h", a, b, c, {co32, res32}, ok, exp);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    test_random_w8();
    test_random_w32();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_nibble_sequencer.md
Name: rca_nibble_sequencer

Overview:
- Multi-cycle wide adder controller that sits directly around the team's 4-bit ripple-carry adder (rca_using_full_adder).
- Accepts two WIDTH-bit operands and feeds the adder one nibble per cycle, LSB nibble first.
- Feeds each adder cout back as the next nibble's cin, and assembles the adder sum nibbles into a WIDTH-bit result plus final carry.
- Lets one small 4-bit adder perform 8/16/32-bit additions with a start/done handshake.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB (localparam), WIDTH/4, number of adder passes per operation.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when ready=1.
- op_a  input  WIDTH  operand A; sampled at the accepting edge.
- op_b  input  WIDTH  operand B; sampled at the accepting edge.
- cin  input  1  initial carry-in; sampled at the accepting edge.
- ready  output  1  high only in IDLE.
- busy  output  1  high only in RUN.
- done  output  1  one-cycle pulse, high in DONE.
- result  output  WIDTH  registered sum.
- carry_out  output  1  registered final carry.
- add_a  output  4  adder operand A nibble.
- add_b  output  4  adder operand B nibble.
- add_cin  output  1  adder carry-in.
- add_sum  input  4  adder sum, combinational return.
- add_cout  input  1  adder carry-out, combinational return.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; shift registers, nibble counter and carry register cleared.
  - result=0, carry_out=0, done=0, busy=0; ready=1 (decoded from state).
- States: IDLE, RUN, DONE.
- IDLE: ready=1. start=1 at an edge causes:
  - a_sh<=op_a, b_sh<=op_b, c_reg<=cin, cnt<=0, state<=RUN.
  - result and carry_out are not modified at the accept edge.
- RUN (busy=1):
  - add_a=a_sh[3:0], add_b=b_sh[3:0], add_cin=c_reg; all combinational from registers, no internal logic between adder output and capture.
  - Each edge: result<={add_sum, result[WIDTH-1:4]}; c_reg<=add_cout; a_sh and b_sh shift right by 4, zero-filled; cnt<=cnt+1.
  - On the edge where cnt==NIB-1: carry_out<=add_cout, state<=DONE.
- DONE: done=1 for exactly one cycle, ready=0; next edge state<=IDLE.
- Latency: start accepted at edge 0; nibbles captured at edges 1..NIB; done high in the cycle after edge NIB. WIDTH=16 gives 4 busy cycles and done 4 edges after accept. WIDTH=4 gives a single RUN cycle.
- Outside RUN: add_a=0, add_b=0, add_cin=0.
- result and carry_out hold their values from the DONE cycle until the next operation's first capture edge.
- start during RUN or DONE is ignored; op_a, op_b and cin changes after accept have no effect.
- start held high continuously: the next operation is accepted on the edge ending the IDLE cycle that follows DONE. Minimum issue interval is NIB+2 cycles.
- Reset during RUN/DONE: the operation is aborted, no done pulse, all outputs go to reset values immediately.
- Arithmetic: {carry_out,result} == op_a + op_b + cin, modulo 2^(WIDTH+1), i.e. exact.
- cnt is sized $clog2(NIB)+1 bits; no wrap is used.

Test Plan:
- Bench setup: WIDTH=16, with rca_using_full_adder connected to the add_* ports.
- 0x1234 + 0x4321, cin=0 -> result=0x5555, carry_out=0; done exactly 4 edges after the accept edge, one cycle wide; busy high for 4 cycles.
- 0xFFFF + 0x0001, cin=0 -> result=0x0000, carry_out=1. Per-nibble add_cin trace: 0,1,1,1.
- 0xFFFF + 0xFFFF, cin=1 -> result=0xFFFF, carry_out=1. Then 0x8000 + 0x8000, cin=0 -> result=0x0000, carry_out=1.
- Accept 0x00FF + 0x0001; during RUN pulse start with 0xAAAA/0x5555 and change op_a -> result=0x0100, carry_out=0; second request ignored; ready=0 throughout RUN and DONE.
- start held high with operands 0x0001/0x0001 -> done every 6 cycles, result=0x0002. Between operations result is stable until the first capture edge.
- Reset mid-run: accept 0x1111 + 0x2222, assert rst_n=0 after 2 captures -> result=0, carry_out=0, done never pulses, ready=1. After release, 0x1111 + 0x2222 -> 0x3333.
- Randomized 1000 operations at WIDTH=8 and WIDTH=32 -> {carry_out,result} matches the reference sum.
